nibbler_sequencer: RTL

Instruction sequencer for the Nibbler 4-bit CPU. It owns the 12-bit program counter, fetches 8-bit instructions from program ROM, and decodes them. It drives ALU, accumulator and flag-register control, and resolves conditional jumps from the stored flags. It sits between program ROM, data RAM/IO, and the datapath: accumulator, ALU and the 2-bit flag register holding {notC, notZ}.

---
 rtl/nibbler_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nibbler_sequencer.sv
// -----------------------------------------------------------------------------
// nibbler_sequencer
//
// Instruction sequencer for the Nibbler 4-bit CPU. Owns the 12-bit program
// counter, fetches one- and two-byte instructions from program ROM and drives
// the datapath controls: ALU operation and operand source, accumulator and
// flag-register load strobes, and RAM / IO access handshakes. Conditional
// jumps are resolved from the stored flags {notC, notZ}.
//
// Each instruction runs as FETCH -> [ADDR] -> EXEC -> FETCH. ADDR appears
// only for two-byte opcodes, where it captures the low address byte.
//
// Ports
//   clk        in   1  clock
//   reset      in   1  asynchronous, active-high reset
//   run        in   1  allow fetch; low holds in FETCH with pc frozen
//   instr      in   8  ROM data at address pc (combinational)
//   pc         out 12  program counter / ROM address
//   flags_n    in   2  stored flags {notC, notZ}
//   operand    out  4  latched low nibble of the opcode byte
//   mem_addr   out 12  {operand, addr_lo}, data RAM address
//   mem_req    out  1  RAM access request (held until mem_ready)
//   mem_we     out  1  RAM write, valid with mem_req
//   mem_ready  in   1  RAM access completes this cycle
//   io_req     out  1  IO access request, port = operand
//   io_we      out  1  IO write, valid with io_req
//   io_ready   in   1  IO access completes this cycle
//   alu_op     out  2  00 ADD, 01 CMP, 10 NOR, 11 PASS B
//   alu_src    out  1  0: B = immediate operand, 1: B = RAM/IO data
//   acc_load   out  1  accumulator captures ALU result at this edge
//   flags_load out  1  flag register captures ALU flags at this edge
// -----------------------------------------------------------------------------
module nibbler_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  instr,
  output logic [11:0] pc,
  input  logic [1:0]  flags_n,
  output logic [3:0]  operand,
  output logic [11:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        io_req,
  output logic        io_we,
  input  logic        io_ready,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        acc_load,
  output logic        flags_load
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_JNZ  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ADDM = 4'h9;
  localparam logic [3:0] OP_CMPI = 4'hA;
  localparam logic [3:0] OP_CMPM = 4'hB;
  localparam logic [3:0] OP_NORI = 4'hC;
  localparam logic [3:0] OP_NORM = 4'hD;
  localparam logic [3:0] OP_LIT  = 4'hE;
  localparam logic [3:0] OP_ST   = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_CMP  = 2'b01;
  localparam logic [1:0] ALU_NOR  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  logic [1:0]  state_q,   state_d;
  logic [11:0] pc_q,      pc_d;
  logic [3:0]  opcode_q,  opcode_d;
  logic [3:0]  operand_q, operand_d;
  logic [7:0]  addr_lo_q, addr_lo_d;

  logic        two_byte;
  logic        jump_taken;

  // Jumps, LD and every memory-operand opcode (odd codes in the upper half)
  // carry a second address byte.
  assign two_byte = (instr[7:4] <= OP_LD) || (instr[7] && instr[4]);

  // flags_n is active-low: a flag is set when its bit reads 0.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode_q)
      OP_JC:   jump_taken = ~flags_n[1];
      OP_JNC:  jump_taken =  flags_n[1];
      OP_JZ:   jump_taken = ~flags_n[0];
      OP_JNZ:  jump_taken =  flags_n[0];
      OP_JMP:  jump_taken = 1'b1;
      default: jump_taken = 1'b0;
    endcase
  end

  // Next-state and control decode. Strobes on memory/IO ops are Mealy on the
  // ready input so the load lands on the same edge the data is valid.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    addr_lo_d  = addr_lo_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    io_req     = 1'b0;
    io_we      = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    acc_load   = 1'b0;
    flags_load = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run) begin
          opcode_d  = instr[7:4];
          operand_d = instr[3:0];
          pc_d      = pc_q + 12'd1;
          state_d   = two_byte ? ST_ADDR : ST_EXEC;
        end
      end

      ST_ADDR: begin
        addr_lo_d = instr;
        pc_d      = pc_q + 12'd1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode_q)
          OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
            // Not taken leaves pc already pointing past the instruction.
            if (jump_taken) pc_d = {operand_q, addr_lo_q};
          end
          OP_LD: begin
            mem_req  = 1'b1;
            alu_src  = 1'b1;
            alu_op   = ALU_PASS;
            acc_load = mem_ready;
            if (!mem_ready) state_d = ST_EXEC;
          end
          OP_IN: begin
            io_req   = 1'b1;
            alu_src  = 1'b1;
            alu_op   = ALU_PASS;
            acc_load = io_ready;
            if (!io_ready) state_d = ST_EXEC;
          end
          OP_OUT: begin
            io_req = 1'b1;
            io_we  = 1'b1;
            if (!io_ready) state_d = ST_EXEC;
          end
          OP_ADDI: begin
            alu_op     = ALU_ADD;
            acc_load   = 1'b1;
            flags_load = 1'b1;
          end
          OP_ADDM: begin
            mem_req    = 1'b1;
            alu_src    = 1'b1;
            alu_op     = ALU_ADD;
            acc_load   = mem_ready;
            flags_load = mem_ready;
            if (!mem_ready) state_d = ST_EXEC;
          end
          OP_CMPI: begin
            alu_op     = ALU_CMP;
            flags_load = 1'b1;
          end
          OP_CMPM: begin
            mem_req    = 1'b1;
            alu_src    = 1'b1;
            alu_op     = ALU_CMP;
            flags_load = mem_ready;
            if (!mem_ready) state_d = ST_EXEC;
          end
          OP_NORI: begin
            alu_op     = ALU_NOR;
            acc_load   = 1'b1;
            flags_load = 1'b1;
          end
          OP_NORM: begin
            mem_req    = 1'b1;
            alu_src    = 1'b1;
            alu_op     = ALU_NOR;
            acc_load   = mem_ready;
            flags_load = mem_ready;
            if (!mem_ready) state_d = ST_EXEC;
          end
          OP_LIT: begin
            alu_op   = ALU_PASS;
            acc_load = 1'b1;
          end
          OP_ST: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            alu_src = 1'b1;
            if (!mem_ready) state_d = ST_EXEC;
          end
          default: ;
        endcase
      end

      // Unused encoding: recover to a clean fetch.
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= 12'h000;
      opcode_q  <= 4'h0;
      operand_q <= 4'h0;
      addr_lo_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      addr_lo_q <= addr_lo_d;
    end
  end

  assign pc       = pc_q;
  assign operand  = operand_q;
  assign mem_addr = {operand_q, addr_lo_q};

endmodule
